// File: rtl/conv_pkg.sv
// Shared pixel/word types, Sobel kernel coefficients and saturation helper
// for the streaming convolution blocks.
package conv_pkg;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_BEAT = 16;
  localparam int WORD_W       = PIX_W * PIX_PER_BEAT;
  localparam int GRAD_W       = 12;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PIX_W-1:0]  pix_t;

  // Indexed [row][col]; row 0 is above the centre, col 0 is left of it.
  localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  function automatic pix_t sat8(input logic [GRAD_W-1:0] v);
    return (v > GRAD_W'(255)) ? '1 : v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_pix.sv
// One-lane Sobel datapath: 3x3 window to signed gradients, and registered
// gradients to an 8-bit magnitude (binary edge map when SOBEL_THRESH_EN).
module sobel_pix
  import conv_pkg::*;
#(
  parameter int THRESH = 128
) (
  input  logic [3*PIX_W-1:0]  row_top,
  input  logic [3*PIX_W-1:0]  row_mid,
  input  logic [3*PIX_W-1:0]  row_bot,
  output logic [GRAD_W-1:0]   gx,
  output logic [GRAD_W-1:0]   gy,
  input  logic [GRAD_W-1:0]   gx_q,
  input  logic [GRAD_W-1:0]   gy_q,
  output logic [PIX_W-1:0]    mag
);
`ifdef SOBEL_THRESH_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif
  localparam logic [GRAD_W-1:0] THR = GRAD_W'(THRESH);

  logic [3*PIX_W-1:0] win [3];
  pix_t               p;
  int                 acc_x;
  int                 acc_y;
  logic [GRAD_W-1:0]  abs_x;
  logic [GRAD_W-1:0]  abs_y;
  logic [GRAD_W-1:0]  sum;

  // Each row slice is {left, centre, right}.
  always_comb begin
    win[0] = row_top;
    win[1] = row_mid;
    win[2] = row_bot;
    p      = '0;
    acc_x  = 0;
    acc_y  = 0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        p     = win[r][(2-c)*PIX_W +: PIX_W];
        acc_x = acc_x + KX[r][c] * int'(p);
        acc_y = acc_y + KY[r][c] * int'(p);
      end
    end
    gx = GRAD_W'(acc_x);
    gy = GRAD_W'(acc_y);
  end

  always_comb begin
    abs_x = gx_q[GRAD_W-1] ? -gx_q : gx_q;
    abs_y = gy_q[GRAD_W-1] ? -gy_q : gy_q;
    sum   = abs_x + abs_y;
    if (BIN_EN) begin
      if (sum >= THR) mag = '1;
      else            mag = '0;
    end else begin
      mag = sat8(sum);
    end
  end
endmodule

// File: rtl/conv_sobel_stream.sv
// Streaming 3x3 Sobel edge detector, PIX_PER_BEAT pixels per word, raster order.
// Optional feature macro: SOBEL_THRESH_EN (binary edge map at THRESH).
module conv_sobel_stream
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH    = 512,
  parameter int IMG_HEIGHT   = 512,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_BEAT = 16,
  parameter int THRESH       = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [PIX_W*PIX_PER_BEAT-1:0] din,
  output logic [PIX_W*PIX_PER_BEAT-1:0] dout
);
  localparam int WW        = PIX_W * PIX_PER_BEAT;
  localparam int EW        = WW + 2 * PIX_W;
  localparam int ROW_BEATS = IMG_WIDTH / PIX_PER_BEAT;
  localparam int BW        = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam int RW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FILL_MAX  = ROW_BEATS + 2;
  localparam int FW        = $clog2(FILL_MAX + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(ROW_BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(FILL_MAX);

  logic [WW-1:0]     lb_mid [ROW_BEATS];
  logic [WW-1:0]     lb_top [ROW_BEATS];
  logic [PIX_W-1:0]  win_l  [3];
  logic [WW-1:0]     win_c  [3];
  logic [WW-1:0]     win_r  [3];
  logic [EW-1:0]     ext    [3];

  logic [BW-1:0]     beat_cnt;
  logic [RW-1:0]     row_cnt;
  logic [BW-1:0]     cen_beat;
  logic [RW-1:0]     cen_row;
  logic [FW-1:0]     fill;
  logic              win_valid;
  logic              g_valid;

  logic [GRAD_W-1:0] gx_c [PIX_PER_BEAT];
  logic [GRAD_W-1:0] gy_c [PIX_PER_BEAT];
  logic [GRAD_W-1:0] gx_q [PIX_PER_BEAT];
  logic [GRAD_W-1:0] gy_q [PIX_PER_BEAT];
  logic [PIX_W-1:0]  mag_c [PIX_PER_BEAT];
  logic [WW-1:0]     mag_word;

  // The window centre is one row and one word behind the newest input word;
  // it becomes meaningful once ROW_BEATS+2 words have been accepted.
  assign win_valid = (fill == FILL_FULL);

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      ext[r] = {win_l[r], win_c[r], win_r[r][WW-1 -: PIX_W]};
      if (cen_beat == '0)       ext[r][EW-1 -: PIX_W] = '0;
      if (cen_beat == LAST_BEAT) ext[r][PIX_W-1:0]    = '0;
    end
    if (cen_row == '0)      ext[0] = '0;
    if (cen_row == LAST_ROW) ext[2] = '0;
  end

  for (genvar l = 0; l < PIX_PER_BEAT; l++) begin : g_lane
    sobel_pix #(.THRESH(THRESH)) u_pix (
      .row_top (ext[0][l*PIX_W +: 3*PIX_W]),
      .row_mid (ext[1][l*PIX_W +: 3*PIX_W]),
      .row_bot (ext[2][l*PIX_W +: 3*PIX_W]),
      .gx      (gx_c[l]),
      .gy      (gy_c[l]),
      .gx_q    (gx_q[l]),
      .gy_q    (gy_q[l]),
      .mag     (mag_c[l])
    );
  end

  always_comb begin
    mag_word = '0;
    for (int unsigned l = 0; l < PIX_PER_BEAT; l++)
      mag_word[l*PIX_W +: PIX_W] = mag_c[l];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROW_BEATS; i++) begin
        lb_mid[i] <= '0;
        lb_top[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_c[r] <= '0;
        win_r[r] <= '0;
      end
      for (int unsigned l = 0; l < PIX_PER_BEAT; l++) begin
        gx_q[l] <= '0;
        gy_q[l] <= '0;
      end
      beat_cnt <= '0;
      row_cnt  <= '0;
      cen_beat <= '0;
      cen_row  <= '0;
      fill     <= '0;
      g_valid  <= 1'b0;
      dout     <= '0;
    end else if (!stall) begin
      lb_top[beat_cnt] <= lb_mid[beat_cnt];
      lb_mid[beat_cnt] <= din;
      for (int unsigned r = 0; r < 3; r++) begin
        win_l[r] <= win_c[r][PIX_W-1:0];
        win_c[r] <= win_r[r];
      end
      win_r[0] <= lb_top[beat_cnt];
      win_r[1] <= lb_mid[beat_cnt];
      win_r[2] <= din;

      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
        row_cnt  <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end

      if (!win_valid) begin
        fill <= fill + FW'(1);
      end else if (cen_beat == LAST_BEAT) begin
        cen_beat <= '0;
        cen_row  <= (cen_row == LAST_ROW) ? '0 : cen_row + RW'(1);
      end else begin
        cen_beat <= cen_beat + BW'(1);
      end

      gx_q    <= gx_c;
      gy_q    <= gy_c;
      g_valid <= win_valid;
      dout    <= g_valid ? mag_word : '0;
    end
  end
endmodule

// File: tb/tb_conv_sobel_stream.sv
// Directed bench for conv_sobel_stream: constant, impulse and step frames,
// a mid-row stall and a mid-frame reset, checked against hand-derived values.
`timescale 1ns/1ps
module tb_conv_sobel_stream;
  localparam int W   = 512;
  localparam int H   = 512;
  localparam int PPB = 16;
  localparam int RB  = W / PPB;
  localparam int LAT = RB + 3;
  localparam int FWD = RB * H;
  localparam int P_CONST = 0;
  localparam int P_IMP   = 1;
  localparam int P_STEP  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [127:0] din;
  logic [127:0] dout;

  always #5 clk = ~clk;

  conv_sobel_stream #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .PIX_W        (8),
    .PIX_PER_BEAT (PPB),
    .THRESH       (128)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .din   (din),
    .dout  (dout)
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  int           adv      = 0;
  logic [127:0] cap [3][FWD];
  logic [127:0] imp_w;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] em(input logic [7:0] v);
`ifdef SOBEL_THRESH_EN
    return (v >= 8'd128) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      P_CONST: return 8'd100;
      P_IMP:   return (r == 100 && c == 100) ? 8'd64 : 8'd0;
      default: return (c >= 256) ? 8'd200 : 8'd0;
    endcase
  endfunction

  function automatic logic [127:0] word_at(input int pat, input int idx);
    logic [127:0] w;
    w = '0;
    for (int p = 0; p < PPB; p++)
      w[(PPB-1-p)*8 +: 8] = pix(pat, idx / RB, (idx % RB) * PPB + p);
    return w;
  endfunction

  function automatic logic [7:0] opix(input int f, input int r, input int c);
    logic [127:0] w;
    w = cap[f][r*RB + c/PPB];
    return w[(PPB-1-(c%PPB))*8 +: 8];
  endfunction

  function automatic int nz(input int f, input int r0, input int r1, input int c0, input int c1);
    int n;
    n = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        if (opix(f, r, c) != 8'd0) n++;
    return n;
  endfunction

  // One advancing word; outputs before the first result must read 0.
  task automatic push(input logic [127:0] w);
    int c;
    din   = w;
    stall = 1'b0;
    @(posedge clk);
    #1;
    adv++;
    c = adv - 1 - LAT;
    if (c < 0) check("dout_before_first_result", dout, '0);
    else if (c < 3*FWD) cap[c/FWD][c%FWD] = dout;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    din   = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout, '0);
    rst = 1'b0;

    imp_w = '0;
    imp_w[12*8 +: 8] = em(8'd128);
    imp_w[10*8 +: 8] = em(8'd128);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FWD; i++) begin
        push(word_at(f, i));
        if (f == P_IMP && i == 3206 + LAT) begin
          check("pre_stall_dout", dout, imp_w);
          for (int s = 0; s < 5; s++) begin
            stall = 1'b1;
            din   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check($sformatf("stall_hold_%0d", s), dout, imp_w);
          end
        end
      end
    end

    // Next frame's first words flush the last results of frame 2.
    for (int i = 0; i < 200*RB + 3; i++) push(word_at(P_CONST, i));

    check("const_0_0",     opix(0, 0, 0),     em(8'd255));
    check("const_0_200",   opix(0, 0, 200),   em(8'd255));
    check("const_511_300", opix(0, 511, 300), em(8'd255));
    check("const_200_0",   opix(0, 200, 0),   em(8'd255));
    check("const_200_511", opix(0, 200, 511), em(8'd255));
    check("const_511_511", opix(0, 511, 511), em(8'd255));
    check("const_200_200", opix(0, 200, 200), '0);
    check("const_interior_nonzero", nz(0, 1, 510, 1, 510), 0);
    check("const_total_nonzero",    nz(0, 0, 511, 0, 511), 2044);

    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0)
          check($sformatf("imp_%0d_%0d", 100+dr, 100+dc), opix(1, 100+dr, 100+dc), em(8'd128));
    check("imp_centre", opix(1, 100, 100), '0);
    check("imp_total_nonzero", nz(1, 0, 511, 0, 511), 8);

    check("step_300_255", opix(2, 300, 255), em(8'd255));
    check("step_300_256", opix(2, 300, 256), em(8'd255));
    check("step_300_511", opix(2, 300, 511), em(8'd255));
    check("step_300_0",   opix(2, 300, 0),   '0);
    check("step_300_1",   opix(2, 300, 1),   '0);
    check("step_300_254", opix(2, 300, 254), '0);
    check("step_300_257", opix(2, 300, 257), '0);
    check("step_300_510", opix(2, 300, 510), '0);
    check("step_interior_nonzero", nz(2, 1, 510, 0, 511), 1530);

    // Centre here is row 198, last word: only col 511 (lane 0) is an edge.
    check("pre_reset_dout", dout, {120'h0, em(8'd255)});
    rst   = 1'b1;
    stall = 1'b1;
    din   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    check("reset_mid_frame_dout", dout, '0);
    rst = 1'b0;
    adv = 0;
    for (int i = 0; i < LAT; i++) push(word_at(P_CONST, i));
    push(word_at(P_CONST, LAT));
    check("first_result_row0_beat0", dout, {16{em(8'd255)}});
    for (int i = LAT + 1; i <= LAT + RB; i++) begin
      push(word_at(P_CONST, i));
      if (i == LAT + 1) check("row0_beat1", dout, {16{em(8'd255)}});
    end
    check("row1_beat0", dout, {em(8'd255), 120'h0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
